// File: rtl/cast_credit_returner.sv
// Destination-side cast credit returner. Drained body flits become batched,
// coordinate-tagged credit tokens for the source's credit counter. Packet lengths are checked too.
module cast_credit_returner #(
  parameter bit          isFC    = 1'b0,
  parameter int unsigned FCpl    = 16,
  parameter int unsigned BATCH   = 4,
  parameter int unsigned MY_X    = 0,
  parameter int unsigned MY_Y    = 0,
  parameter logic [1:0]  FT_HEAD = 2'b00,
  parameter logic [1:0]  FT_BODY = 2'b01,
  parameter logic [1:0]  FT_TAIL = 2'b10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fire,
  input  logic [1:0]  flit_type,
  output logic        crd_vld,
  input  logic        crd_rdy,
  output logic [31:0] crd_val,
  output logic [7:0]  crd_x,
  output logic [7:0]  crd_y,
  output logic [31:0] crd_total,
  output logic        pkt_err
);

  localparam int unsigned CRD_W = 32;
  localparam int unsigned CNT_W = $clog2(FCpl) + 1;
  localparam logic [CRD_W-1:0] PEND_MAX = '1;
  localparam logic [CRD_W-1:0] BATCH_C  = CRD_W'(BATCH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] BODY_EXP = CNT_W'(FCpl - 2);

  typedef enum logic {IDLE, PKT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] body_cnt, body_cnt_nx;
  logic [CRD_W-1:0] pending, pending_nx, pend_sum;
  logic             flush, flush_nx;
  logic             crd_vld_nx;
  logic [CRD_W-1:0] crd_val_nx, crd_total_nx;
  logic             pkt_err_nx;

  logic fire_en, head_fire, body_fire, tail_fire;
  logic xfer, slot_free, issue;

  // Non-FC nodes see no fires, so every register stays at its reset value
  assign fire_en   = fire & isFC;
  assign head_fire = fire_en & (flit_type == FT_HEAD);
  assign body_fire = fire_en & (flit_type == FT_BODY);
  assign tail_fire = fire_en & (flit_type == FT_TAIL);

  assign xfer      = crd_vld & crd_rdy;
  assign slot_free = ~crd_vld | xfer;
  assign pend_sum  = (pending == PEND_MAX) ? PEND_MAX : pending + CRD_W'(body_fire);
  assign issue     = slot_free & (pend_sum != '0) &
                     ((pend_sum >= BATCH_C) | flush | tail_fire);

  assign crd_x = 8'(MY_X);
  assign crd_y = 8'(MY_Y);

  // Credit accumulation and token slot; in-flight token never absorbs new earnings
  always_comb begin
    pending_nx   = pending;
    flush_nx     = flush;
    crd_vld_nx   = crd_vld;
    crd_val_nx   = crd_val;
    crd_total_nx = crd_total + (xfer ? crd_val : '0);
    if (slot_free) begin
      flush_nx = 1'b0;
      if (issue) begin
        crd_vld_nx = 1'b1;
        crd_val_nx = pend_sum;
        pending_nx = '0;
      end else begin
        crd_vld_nx = 1'b0;
        pending_nx = pend_sum;
      end
    end else begin
      pending_nx = pend_sum;
      flush_nx   = flush | tail_fire;
    end
  end

  // Packet framing FSM; errors never block credit earning
  always_comb begin
    state_nx    = state;
    body_cnt_nx = body_cnt;
    pkt_err_nx  = pkt_err;
    case (state)
      IDLE: begin
        if (head_fire) begin
          state_nx    = PKT;
          body_cnt_nx = '0;
        end else if (body_fire | tail_fire) begin
          pkt_err_nx = 1'b1;
        end
      end
      PKT: begin
        if (head_fire) begin
          pkt_err_nx  = 1'b1;
          body_cnt_nx = '0;
        end else if (body_fire) begin
          body_cnt_nx = (body_cnt == CNT_MAX) ? body_cnt : body_cnt + CNT_W'(1);
        end else if (tail_fire) begin
          state_nx = IDLE;
          if (body_cnt != BODY_EXP) pkt_err_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      body_cnt  <= '0;
      pending   <= '0;
      flush     <= 1'b0;
      crd_vld   <= 1'b0;
      crd_val   <= '0;
      crd_total <= '0;
      pkt_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      body_cnt  <= body_cnt_nx;
      pending   <= pending_nx;
      flush     <= flush_nx;
      crd_vld   <= crd_vld_nx;
      crd_val   <= crd_val_nx;
      crd_total <= crd_total_nx;
      pkt_err   <= pkt_err_nx;
    end
  end

endmodule

// File: tb/tb_cast_credit_returner.sv
// Bench for cast_credit_returner: three instances (BATCH=4, BATCH=1, non-FC) on shared stimulus,
// checked every cycle against a behavioural credit/packet model plus directed token sequences.
module tb_cast_credit_returner;

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam int N    = 3;
  localparam int FCPL = 16;

  logic        clk = 1'b0;
  logic        rstn, fire, crd_rdy;
  logic [1:0]  flit_type;
  logic        vld [N];
  logic [31:0] val [N];
  logic [31:0] tot [N];
  logic [7:0]  cx  [N];
  logic [7:0]  cy  [N];
  logic        err [N];

  int checks = 0;
  int failures = 0;

  bit              m_vld   [N];
  logic [31:0]     m_val   [N];
  logic [31:0]     m_tot   [N];
  longint unsigned m_pend  [N];
  bit              m_flush [N];
  bit              m_err   [N];
  bit              m_inpkt [N];
  int              m_bcnt  [N];
  int unsigned     tok_q [$];

  always #5 clk = ~clk;

  cast_credit_returner #(.isFC(1'b1), .FCpl(FCPL), .BATCH(4), .MY_X(3), .MY_Y(5)) dut_a (
    .clk(clk), .rstn(rstn), .fire(fire), .flit_type(flit_type),
    .crd_vld(vld[0]), .crd_rdy(crd_rdy), .crd_val(val[0]), .crd_x(cx[0]), .crd_y(cy[0]),
    .crd_total(tot[0]), .pkt_err(err[0]));

  cast_credit_returner #(.isFC(1'b1), .FCpl(FCPL), .BATCH(1), .MY_X(1), .MY_Y(2)) dut_b (
    .clk(clk), .rstn(rstn), .fire(fire), .flit_type(flit_type),
    .crd_vld(vld[1]), .crd_rdy(crd_rdy), .crd_val(val[1]), .crd_x(cx[1]), .crd_y(cy[1]),
    .crd_total(tot[1]), .pkt_err(err[1]));

  cast_credit_returner #(.isFC(1'b0), .FCpl(FCPL), .BATCH(4), .MY_X(0), .MY_Y(0)) dut_z (
    .clk(clk), .rstn(rstn), .fire(fire), .flit_type(flit_type),
    .crd_vld(vld[2]), .crd_rdy(crd_rdy), .crd_val(val[2]), .crd_x(cx[2]), .crd_y(cy[2]),
    .crd_total(tot[2]), .pkt_err(err[2]));

  function automatic longint unsigned batch_of(input int k);
    return (k == 1) ? 64'd1 : 64'd4;
  endfunction

  function automatic bit fc_of(input int k);
    return k != 2;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_vld[k] = 0; m_val[k] = '0; m_tot[k] = '0; m_pend[k] = 0;
      m_flush[k] = 0; m_err[k] = 0; m_inpkt[k] = 0; m_bcnt[k] = 0;
    end
  endtask

  // One clock of the credit-loop rules applied to the model of instance k
  task automatic model_cycle(input int k, input bit f, input logic [1:0] t, input bit r);
    bit xfer, earn, tail, head;
    longint unsigned p;
    if (!fc_of(k)) return;
    head = f && (t == FT_HEAD);
    earn = f && (t == FT_BODY);
    tail = f && (t == FT_TAIL);
    xfer = m_vld[k] && r;
    if (xfer) m_tot[k] = m_tot[k] + m_val[k];
    p = m_pend[k] + 64'(earn);
    if (p > 64'hFFFF_FFFF) p = 64'hFFFF_FFFF;
    if (!m_vld[k] || xfer) begin
      if (p > 0 && (p >= batch_of(k) || m_flush[k] || tail)) begin
        m_vld[k] = 1; m_val[k] = 32'(p); m_pend[k] = 0;
      end else begin
        m_vld[k] = 0; m_pend[k] = p;
      end
      m_flush[k] = 0;
    end else begin
      m_pend[k]  = p;
      m_flush[k] = m_flush[k] | tail;
    end
    if (head) begin
      if (m_inpkt[k]) m_err[k] = 1;
      m_inpkt[k] = 1; m_bcnt[k] = 0;
    end else if (earn) begin
      if (!m_inpkt[k]) m_err[k] = 1;
      else m_bcnt[k]++;
    end else if (tail) begin
      if (!m_inpkt[k] || m_bcnt[k] != FCPL - 2) m_err[k] = 1;
      m_inpkt[k] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < N; k++) begin
      check({tag, "_vld"}, k, 32'(vld[k]), 32'(m_vld[k]));
      check({tag, "_val"}, k, val[k], m_val[k]);
      check({tag, "_total"}, k, tot[k], m_tot[k]);
      check({tag, "_err"}, k, 32'(err[k]), 32'(m_err[k]));
    end
  endtask

  task automatic step(input bit f, input logic [1:0] t, input bit r);
    fire = f; flit_type = t; crd_rdy = r;
    if (vld[0] && r) tok_q.push_back(val[0]);
    for (int k = 0; k < N; k++) model_cycle(k, f, t, r);
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic send_pkt(input int nbody, input bit r);
    step(1'b1, FT_HEAD, r);
    repeat (nbody) step(1'b1, FT_BODY, r);
    step(1'b1, FT_TAIL, r);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, FT_HEAD, 1'b1);
  endtask

  // Reset lands mid-cycle so outputs must clear without a clock edge
  task automatic do_reset();
    #2;
    rstn = 1'b0; fire = 1'b0; crd_rdy = 1'b0;
    #1;
    model_reset();
    compare_all("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    tok_q.delete();
  endtask

  task automatic check_tokens(input string tag, input int n,
                              input int unsigned e0, input int unsigned e1,
                              input int unsigned e2, input int unsigned e3);
    int unsigned e [4];
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, 0, 32'(tok_q.size()), 32'(n));
    for (int i = 0; i < n && i < tok_q.size(); i++)
      check($sformatf("%s_tok%0d", tag, i), 0, tok_q[i], e[i]);
    tok_q.delete();
  endtask

  initial begin
    rstn = 1'b0; fire = 1'b0; flit_type = FT_HEAD; crd_rdy = 1'b0;
    do_reset();
    check("coord_x", 0, 32'(cx[0]), 32'd3);
    check("coord_y", 0, 32'(cy[0]), 32'd5);
    check("coord_x", 1, 32'(cx[1]), 32'd1);
    check("coord_y", 1, 32'(cy[1]), 32'd2);

    // Clean packet, channel always ready
    send_pkt(14, 1'b1);
    idle(2);
    check_tokens("clean", 4, 4, 4, 4, 2);
    check("clean_total", 0, tot[0], 32'd14);
    check("clean_total", 1, tot[1], 32'd14);
    check("clean_err", 0, 32'(err[0]), 32'd0);

    // Channel stalls for ten cycles right after the first token
    do_reset();
    step(1'b1, FT_HEAD, 1'b1);
    repeat (4) step(1'b1, FT_BODY, 1'b1);
    repeat (10) begin
      step(1'b1, FT_BODY, 1'b0);
      check("stall_hold", 0, val[0], 32'd4);
    end
    step(1'b1, FT_TAIL, 1'b1);
    idle(2);
    check_tokens("stall", 2, 4, 10, 0, 0);
    check("stall_total", 0, tot[0], 32'd14);

    // Short packet flags an error but still returns every credit
    do_reset();
    send_pkt(13, 1'b1);
    check("short_err", 0, 32'(err[0]), 32'd1);
    idle(2);
    check_tokens("short", 4, 4, 4, 4, 1);
    check("short_total", 0, tot[0], 32'd13);

    // Body flit without a head
    do_reset();
    step(1'b1, FT_BODY, 1'b1);
    check("orphan_err", 0, 32'(err[0]), 32'd1);
    check("orphan_err", 1, 32'(err[1]), 32'd1);
    check("orphan_err", 2, 32'(err[2]), 32'd0);
    idle(2);

    // Five back-to-back packets: BATCH=1 transfers every cycle alongside new earnings
    do_reset();
    repeat (5) send_pkt(14, 1'b1);
    idle(2);
    check("five_total", 1, tot[1], 32'd70);
    check("five_total", 0, tot[0], 32'd70);

    // Reset with a token in flight and three credits pending
    do_reset();
    step(1'b1, FT_HEAD, 1'b0);
    repeat (7) step(1'b1, FT_BODY, 1'b0);
    check("pre_rst_vld", 0, 32'(vld[0]), 32'd1);
    check("pre_rst_pend", 0, 32'(m_pend[0]), 32'd3);
    do_reset();
    send_pkt(14, 1'b1);
    idle(2);
    check_tokens("post_rst", 4, 4, 4, 4, 2);

    // Random traffic against the model
    do_reset();
    repeat (400)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), $urandom_range(0, 3) != 0);
    idle(3);
    check("inert_vld", 2, 32'(vld[2]), 32'd0);
    check("inert_total", 2, tot[2], 32'd0);
    check("inert_err", 2, 32'(err[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
